lsu_riscv: RTL and testbench
============================

Name: lsu_riscv

Overview:
Load-store unit sitting directly downstream of the instruction decoder. It consumes the decoder's mem_req/mem_we/mem_size controls, plus the ALU address and the rs2 store data. It performs one registered, handshaked access to external data memory and returns sign- or zero-extended load data for write-back. It stalls the core while an access is outstanding, flags misaligned accesses without touching memory, and can abort on a bus timeout.

Parameters:
TIMEOUT_CYCLES, 0, cycles spent in BUSY without mem_ready_i before the access is aborted; 0 disables the timeout.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
core_req_i  in  1  memory request from decoder (mem_req_o)
core_we_i  in  1  1 = store, 0 = load (decoder mem_we_o)
core_size_i  in  3  0 B, 1 H, 2 W, 4 BU, 5 HU (decoder mem_size_o)
core_addr_i  in  32  byte address from ALU
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  extended load data, valid when core_req_i=1 and core_stall_o=0
core_stall_o  out  1  holds PC/pipeline while the access is outstanding
core_misalign_o  out  1  one-cycle misaligned-access pulse (load or store)
core_fault_o  out  1  one-cycle bus-timeout pulse
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable, registered
mem_be_o  out  4  byte enables, registered
mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), registered
mem_wd_o  out  32  store data replicated to lanes, registered
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  access complete; sampled only in BUSY

Behaviour:
- Reset: async on rst_ni=0.
  - State goes to IDLE.
  - mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0, timeout counter=0.
  - core_stall_o=0, core_misalign_o=0, core_fault_o=0, core_rd_o=0.
  - Reset during BUSY drops mem_req_o immediately. No completion is reported.
- FSM states: IDLE, BUSY.
- IDLE, core_req_i=1, aligned:
  - Latch we, size, addr[1:0], addr, be, and wd into output registers.
  - mem_req_o=1 from the next edge. Go to BUSY.
  - core_stall_o=1 combinationally in this cycle.
- IDLE, core_req_i=1, misaligned:
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No memory request; stay in IDLE.
  - core_misalign_o=1 (combinational pulse), core_stall_o=0.
- Illegal size (3, 6, 7): treated as misaligned.
- BUSY, mem_ready_i=0:
  - core_stall_o=1. All mem_* outputs are held stable. Counter increments.
- BUSY, mem_ready_i=1:
  - core_stall_o=0. For loads, core_rd_o is extracted from mem_rd_i using the latched offset and size.
  - Next edge: mem_req_o=0, counter cleared, go to IDLE.
  - Minimum access latency is 2 cycles (issue, ready). Back-to-back accesses are separated by one IDLE issue cycle.
- BUSY, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with mem_ready_i=0:
  - core_fault_o=1 and core_stall_o=0 this cycle.
  - Next edge: mem_req_o=0, go to IDLE.
  - mem_ready_i arriving in the same cycle wins: normal completion, no fault.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- Store data:
  - B: replicated {4{wd[7:0]}}.
  - H: replicated {2{wd[15:0]}}.
  - W: as-is.
  - Loads drive mem_wd_o=0.
- Load extract:
  - B/BU: byte at offset, sign- or zero-extended.
  - H/HU: half at offset[1], sign- or zero-extended.
  - W: full word.
- core_req_i changing while BUSY is ignored; the latched request is authoritative.

Decomposition:
- riscv_pkg gains:
  - The LDST_B/H/W/BU/HU size constants, shared with the decoder.
  - An lsu_state_t enum {IDLE, BUSY}.
- One natural sub-module, lsu_load_extract: combinational offset/size/mem_rd_i -> core_rd_o.

Test Plan:
- Store word: addr 0x100, wd 0xDEADBEEF, ready after 3 BUSY cycles. Expect be=4'b1111, addr 0x100, wd 0xDEADBEEF, stall=1 for 4 cycles total, then 0, mem_req drops.
- Store byte: addr 0x103, wd 0x000000A5. Expect be=4'b1000, wd 0xA5A5A5A5.
- Load B and BU: addr 0x102, mem_rd 0x12F0_3456, ready on first BUSY cycle. Expect rd 0xFFFFFFF0 (B) and 0x000000F0 (BU); stall for exactly 1 cycle.
- Misaligned: LW at 0x101 and LH at 0x103. Expect core_misalign_o pulse, stall=0, mem_req_o never asserted.
- Timeout: TIMEOUT_CYCLES=4, mem_ready_i held 0. Expect fault pulse in the 4th BUSY cycle, then IDLE. A repeat run with ready arriving in that same cycle gives completion and no fault.
- Reset mid-BUSY: assert rst_ni=0 asynchronously. Expect mem_req_o=0 and stall=0 before the next clock edge, and a clean new access after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size codes, LSU state, memory payload
// and the lane helpers used when issuing a data-memory access.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Size codes shared with the decoder's mem_size output
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wd;
  } lsu_mem_req_t;

  // Illegal size codes are reported as misaligned so they never reach memory.
  function automatic logic ldst_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b1;
    case (size)
      LDST_B, LDST_BU: mis = 1'b0;
      LDST_H, LDST_HU: mis = off[0];
      LDST_W:          mis = |off;
      default:         mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [BE_W-1:0] ldst_be(input logic [2:0] size, input logic [1:0] off);
    logic [BE_W-1:0] be;
    be = '1;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = 4'b0011 << off;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] ldst_wdata(input logic we, input logic [2:0] size,
                                                 input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] data;
    data = wd;
    case (size)
      LDST_B, LDST_BU: data = {4{wd[7:0]}};
      LDST_H, LDST_HU: data = {2{wd[15:0]}};
      default:         data = wd;
    endcase
    if (!we) data = '0;
    return data;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/half/word from a memory read word and sign- or
// zero-extends it for write-back.
module lsu_load_extract
  import riscv_pkg::*;
(
  input  logic [1:0]      offset,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'd0, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_riscv.sv
// Load-store unit: issues one registered, handshaked data-memory access per request,
// stalls the core while it is outstanding, flags misalignment and bus timeouts.
module lsu_riscv
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [2:0]      core_size_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wd_i,
  output logic [XLEN-1:0] core_rd_o,
  output logic            core_stall_o,
  output logic            core_misalign_o,
  output logic            core_fault_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wd_o,
  input  logic [XLEN-1:0] mem_rd_i,
  input  logic            mem_ready_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t       state_q, state_d;
  lsu_mem_req_t     mem_q, issue_payload;
  logic             req_q;
  logic [2:0]       size_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;

  logic             misaligned, timeout_hit;
  logic             issue, done, stall, misalign, fault, load_valid;
  logic [XLEN-1:0]  load_data;

  assign misaligned  = ldst_misaligned(core_size_i, core_addr_i[1:0]);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    issue_payload.we   = core_we_i;
    issue_payload.be   = ldst_be(core_size_i, core_addr_i[1:0]);
    issue_payload.addr = {core_addr_i[XLEN-1:2], 2'b00};
    issue_payload.wd   = ldst_wdata(core_we_i, core_size_i, core_wd_i);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle handshake controls
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    fault      = 1'b0;
    load_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            issue   = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (mem_ready_i) begin
          done       = 1'b1;
          load_valid = !mem_q.we;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          done    = 1'b1;
          fault   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched access and timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      mem_q  <= '0;
      size_q <= LDST_B;
      off_q  <= 2'd0;
      cnt_q  <= '0;
    end else if (issue) begin
      req_q  <= 1'b1;
      mem_q  <= issue_payload;
      size_q <= core_size_i;
      off_q  <= core_addr_i[1:0];
      cnt_q  <= '0;
    end else if (done) begin
      req_q <= 1'b0;
      cnt_q <= '0;
    end else if (TIMEOUT_EN && state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  lsu_load_extract u_load_extract (
    .offset (off_q),
    .size   (size_q),
    .rdata  (mem_rd_i),
    .data   (load_data)
  );

  assign mem_req_o  = req_q;
  assign mem_we_o   = mem_q.we;
  assign mem_be_o   = mem_q.be;
  assign mem_addr_o = mem_q.addr;
  assign mem_wd_o   = mem_q.wd;

  // Core-side handshake is combinational; forced quiet while reset is held.
  assign core_stall_o    = rst_ni && stall;
  assign core_misalign_o = rst_ni && misalign;
  assign core_fault_o    = rst_ni && fault;
  assign core_rd_o       = (rst_ni && load_valid) ? load_data : '0;

endmodule

// File: tb/tb_lsu_riscv.sv
// Self-checking bench for lsu_riscv: directed scenarios plus randomized accesses
// compared against a lane-level reference model.
module tb_lsu_riscv;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        stall, misalign, fault;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_riscv #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .core_req_i      (core_req),
    .core_we_i       (core_we),
    .core_size_i     (core_size),
    .core_addr_i     (core_addr),
    .core_wd_i       (core_wd),
    .core_rd_o       (core_rd),
    .core_stall_o    (stall),
    .core_misalign_o (misalign),
    .core_fault_o    (fault),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_be_o        (mem_be),
    .mem_addr_o      (mem_addr),
    .mem_wd_o        (mem_wd),
    .mem_rd_i        (mem_rd),
    .mem_ready_i     (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access from IDLE; delay = BUSY cycles with ready low before ready (>= TO means timeout).
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int delay);
    int          nbytes, off;
    logic        mis, sgn;
    logic [3:0]  be_e;
    logic [31:0] wd_e, rd_e, shifted;

    off = int'(addr[1:0]);
    case (size)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    nbytes = 0;
    endcase
    mis = (nbytes == 0) || ((off % nbytes) != 0);
    sgn = (size < 3'd4);
    be_e = 4'd0;
    wd_e = 32'd0;
    for (int i = 0; i < 4; i++) begin
      be_e[i] = (nbytes != 0) && (i >= off) && (i < off + nbytes);
      if (we && nbytes != 0) wd_e[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    end
    shifted = rdata >> (8 * off);
    rd_e = shifted;
    for (int b = 8 * nbytes; b < 32; b++) rd_e[b] = sgn ? shifted[8*nbytes-1] : 1'b0;

    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_ready = 1'b0;
    @(negedge clk);
    if (mis) begin
      check("mis_pulse", misalign, 1);
      check("mis_stall", stall, 0);
      check("mis_req", mem_req, 0);
      @(posedge clk); #1;
      core_req = 1'b0;
      check("mis_noreq", mem_req, 0);
      return;
    end
    check("issue_stall", stall, 1);
    check("issue_mis", misalign, 0);
    @(posedge clk); #1;
    core_addr = $urandom; core_wd = $urandom; core_we = ~we; core_size = 3'($urandom);
    for (int k = 0; k < 16; k++) begin
      mem_ready = (k == delay);
      mem_rd    = (k == delay) ? rdata : $urandom;
      @(negedge clk);
      check("busy_req", mem_req, 1);
      check("busy_we", mem_we, we);
      check("busy_be", mem_be, be_e);
      check("busy_addr", mem_addr, {addr[31:2], 2'b00});
      check("busy_wd", mem_wd, wd_e);
      if (k == delay) begin
        check("done_stall", stall, 0);
        check("done_fault", fault, 0);
        if (!we) check("load_rd", core_rd, rd_e);
      end else if (k == TO - 1) begin
        check("to_fault", fault, 1);
        check("to_stall", stall, 0);
      end else begin
        check("wait_stall", stall, 1);
        check("wait_fault", fault, 0);
      end
      @(posedge clk); #1;
      if (k == delay || k == TO - 1) break;
    end
    mem_ready = 1'b0;
    core_req  = 1'b0;
    @(negedge clk);
    check("idle_req", mem_req, 0);
    check("idle_stall", stall, 0);
    check("idle_fault", fault, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] sz_tab [10];
    sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd0};

    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0; mem_ready = 1'b0;
    #3;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wd", mem_wd, 0);
    check("rst_stall", stall, 0);
    check("rst_mis", misalign, 0);
    check("rst_fault", fault, 0);
    check("rst_rd", core_rd, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3);
    access(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    access(1'b0, 3'd0, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0);
    access(1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0);
    access(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0);
    access(1'b0, 3'd1, 32'h0000_0103, 32'h0, 32'h0, 0);
    access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 10);
    access(1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h8765_4321, TO - 1);
    access(1'b1, 3'd1, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 1);

    // Reset asserted while an access is outstanding
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h0000_0300;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1; core_req = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 3'd1, 32'h0000_0404, 32'h0, 32'h0000_8001, 1);

    for (int n = 0; n < 60; n++) begin
      access(1'($urandom), sz_tab[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
